// File: rtl/marcador_pkg.sv
// -----------------------------------------------------------------------------
// marcador_pkg
// Shared definitions for the score-to-ASCII sequencer: FSM state encoding,
// ASCII constants, digit count, the BCD digit type, and the small helpers
// used by the double-dabble converter and the character formatter.
// -----------------------------------------------------------------------------
package marcador_pkg;

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        CONVERTIR = 2'd1,
        EMITIR    = 2'd2,
        FIN       = 2'd3
    } estado_t;

    localparam logic [7:0] ASCII_CERO    = 8'h30;
    localparam logic [7:0] ASCII_ESPACIO = 8'h20;
    localparam int         DIGITOS       = 3;

    typedef logic [3:0] digito_t;

    // Double-dabble correction: a nibble of 5 or more would overflow past 9
    // after the next shift, so it is pre-adjusted by 3.
    function automatic digito_t ajuste_bcd(input digito_t d);
        digito_t r;
        if (d >= 4'd5) begin
            r = d + 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

    function automatic logic [7:0] digito_a_ascii(input digito_t d);
        return ASCII_CERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/bin_a_bcd_serial.sv
// -----------------------------------------------------------------------------
// bin_a_bcd_serial
// Serial binary-to-BCD converter (shift / add-3). One bit is consumed per
// clock; the result is ready exactly ANCHO cycles after the start strobe.
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   arranque   in   start strobe; loads `binario` and restarts the loop
//   binario    in   ANCHO-bit binary value (must be <= 999)
//   listo_bcd  out  one-cycle pulse: digit outputs hold the final result
//   centenas   out  hundreds digit
//   decenas    out  tens digit
//   unidades   out  units digit
// -----------------------------------------------------------------------------
module bin_a_bcd_serial
    import marcador_pkg::*;
#(
    parameter int ANCHO = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             arranque,
    input  logic [ANCHO-1:0] binario,
    output logic             listo_bcd,
    output digito_t          centenas,
    output digito_t          decenas,
    output digito_t          unidades
);

    localparam int CW = $clog2(ANCHO + 1);

    logic [11:0]      bcd_r;
    logic [11:0]      bcd_ajustado_s;
    logic [ANCHO-1:0] desp_r;
    logic [CW-1:0]    cuenta_r;
    logic             activo_r;
    logic             listo_r;

    // Add-3 correction applied to every nibble before the shift.
    always_comb begin
        bcd_ajustado_s = {ajuste_bcd(bcd_r[11:8]), ajuste_bcd(bcd_r[7:4]), ajuste_bcd(bcd_r[3:0])};
    end

    // Shift/add-3 loop with iteration counter; listo pulses after the last bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd_r    <= 12'h000;
            desp_r   <= '0;
            cuenta_r <= '0;
            activo_r <= 1'b0;
            listo_r  <= 1'b0;
        end else if (arranque) begin
            bcd_r    <= 12'h000;
            desp_r   <= binario;
            cuenta_r <= CW'(ANCHO);
            activo_r <= 1'b1;
            listo_r  <= 1'b0;
        end else if (activo_r) begin
            bcd_r    <= {bcd_ajustado_s[10:0], desp_r[ANCHO-1]};
            desp_r   <= {desp_r[ANCHO-2:0], 1'b0};
            cuenta_r <= cuenta_r - CW'(1);
            if (cuenta_r == CW'(1)) begin
                activo_r <= 1'b0;
                listo_r  <= 1'b1;
            end else begin
                listo_r  <= 1'b0;
            end
        end else begin
            listo_r <= 1'b0;
        end
    end

    assign listo_bcd = listo_r;
    assign centenas  = bcd_r[11:8];
    assign decenas   = bcd_r[7:4];
    assign unidades  = bcd_r[3:0];

endmodule

// File: rtl/marcador_ascii_secuenciador.sv
// -----------------------------------------------------------------------------
// marcador_ascii_secuenciador
// Converts a binary score into up to three decimal ASCII characters and
// streams them MSD first over a valid/ready byte interface. Leading zeros
// are skipped; with MARCADOR_RELLENO_ESPACIO_EN defined they are sent as
// spaces instead, giving a fixed three-character field.
//
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset (aborts any conversion)
//   inicio      in   start strobe, only honoured while idle
//   puntaje     in   binary score, captured with inicio
//   ocupado     out  high whenever not idle
//   car_dato    out  ASCII character
//   car_valido  out  car_dato valid
//   car_listo   in   downstream ready
//   car_ultimo  out  marks the final character of the number
//   fin         out  one-cycle pulse after the final transfer
//   desbordado  out  score was clamped to MAX_PUNTAJE; held until next start
// -----------------------------------------------------------------------------
module marcador_ascii_secuenciador
    import marcador_pkg::*;
#(
    parameter int ANCHO_PUNTAJE = 10,
    parameter int MAX_PUNTAJE   = 999
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     inicio,
    input  logic [ANCHO_PUNTAJE-1:0] puntaje,
    output logic                     ocupado,
    output logic [7:0]               car_dato,
    output logic                     car_valido,
    input  logic                     car_listo,
    output logic                     car_ultimo,
    output logic                     fin,
    output logic                     desbordado
);

    localparam logic [ANCHO_PUNTAJE-1:0] TOPE       = ANCHO_PUNTAJE'(MAX_PUNTAJE);
    localparam logic [1:0]               PTR_ULTIMO = 2'(DIGITOS - 1);

    estado_t                    estado_r, estado_s;
    logic                       arranque_s;
    logic [ANCHO_PUNTAJE-1:0]   binario_s;
    logic                       listo_bcd_s;
    digito_t                    cen_bcd_s, dec_bcd_s, uni_bcd_s;
    digito_t                    cen_r, dec_r, uni_r;
    digito_t                    cen_s, dec_s, uni_s;
    logic [1:0]                 ptr_r, ptr_s;
    logic [7:0]                 car_dato_r, car_dato_s;
    logic                       car_valido_r, car_valido_s;
    logic                       car_ultimo_r, car_ultimo_s;
    logic                       fin_r, fin_s;
    logic                       ocupado_r, ocupado_s;
    logic                       desbordado_r, desbordado_s;

    // A leading digit is suppressed when it and every digit above it are zero.
    function automatic logic suprimido(input logic [1:0] p, input digito_t c, input digito_t d);
        return ((p == 2'd0) && (c == 4'd0)) || ((p == 2'd1) && (c == 4'd0) && (d == 4'd0));
    endfunction

    function automatic logic [1:0] primer_puntero(input digito_t c, input digito_t d);
        logic [1:0] p;
`ifdef MARCADOR_RELLENO_ESPACIO_EN
        p = 2'd0;
`else
        if (!suprimido(2'd0, c, d)) begin
            p = 2'd0;
        end else if (!suprimido(2'd1, c, d)) begin
            p = 2'd1;
        end else begin
            p = 2'd2;
        end
`endif
        return p;
    endfunction

    function automatic logic [7:0] caracter(input logic [1:0] p, input digito_t c,
                                            input digito_t d, input digito_t u);
        logic [7:0] r;
`ifdef MARCADOR_RELLENO_ESPACIO_EN
        if (suprimido(p, c, d)) begin
            r = ASCII_ESPACIO;
        end else begin
`else
        begin
`endif
            case (p)
                2'd0:    r = digito_a_ascii(c);
                2'd1:    r = digito_a_ascii(d);
                2'd2:    r = digito_a_ascii(u);
                default: r = ASCII_ESPACIO;
            endcase
        end
        return r;
    endfunction

    bin_a_bcd_serial #(
        .ANCHO (ANCHO_PUNTAJE)
    ) u_bcd (
        .clk       (clk),
        .reset_n   (reset_n),
        .arranque  (arranque_s),
        .binario   (binario_s),
        .listo_bcd (listo_bcd_s),
        .centenas  (cen_bcd_s),
        .decenas   (dec_bcd_s),
        .unidades  (uni_bcd_s)
    );

    // Next-state and next-output logic; every register holds unless updated.
    always_comb begin
        estado_s     = estado_r;
        arranque_s   = 1'b0;
        binario_s    = (puntaje > TOPE) ? TOPE : puntaje;
        cen_s        = cen_r;
        dec_s        = dec_r;
        uni_s        = uni_r;
        ptr_s        = ptr_r;
        car_dato_s   = car_dato_r;
        car_valido_s = car_valido_r;
        car_ultimo_s = car_ultimo_r;
        fin_s        = 1'b0;
        desbordado_s = desbordado_r;
        case (estado_r)
            REPOSO: begin
                if (inicio) begin
                    arranque_s   = 1'b1;
                    desbordado_s = (puntaje > TOPE);
                    estado_s     = CONVERTIR;
                end else begin
                    estado_s = REPOSO;
                end
            end
            CONVERTIR: begin
                if (listo_bcd_s) begin
                    cen_s        = cen_bcd_s;
                    dec_s        = dec_bcd_s;
                    uni_s        = uni_bcd_s;
                    ptr_s        = primer_puntero(cen_bcd_s, dec_bcd_s);
                    car_dato_s   = caracter(ptr_s, cen_bcd_s, dec_bcd_s, uni_bcd_s);
                    car_valido_s = 1'b1;
                    car_ultimo_s = (ptr_s == PTR_ULTIMO);
                    estado_s     = EMITIR;
                end else begin
                    estado_s = CONVERTIR;
                end
            end
            EMITIR: begin
                if (car_valido_r && car_listo) begin
                    if (car_ultimo_r) begin
                        car_valido_s = 1'b0;
                        car_ultimo_s = 1'b0;
                        fin_s        = 1'b1;
                        estado_s     = FIN;
                    end else begin
                        ptr_s        = ptr_r + 2'd1;
                        car_dato_s   = caracter(ptr_s, cen_r, dec_r, uni_r);
                        car_ultimo_s = (ptr_s == PTR_ULTIMO);
                        estado_s     = EMITIR;
                    end
                end else begin
                    estado_s = EMITIR;
                end
            end
            FIN: begin
                estado_s = REPOSO;
            end
            default: begin
                estado_s = REPOSO;
            end
        endcase
        ocupado_s = (estado_s != REPOSO);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_r <= REPOSO;
        end else begin
            estado_r <= estado_s;
        end
    end

    // Digit latches, emission pointer and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cen_r        <= 4'd0;
            dec_r        <= 4'd0;
            uni_r        <= 4'd0;
            ptr_r        <= 2'd0;
            car_dato_r   <= 8'h00;
            car_valido_r <= 1'b0;
            car_ultimo_r <= 1'b0;
            fin_r        <= 1'b0;
            ocupado_r    <= 1'b0;
            desbordado_r <= 1'b0;
        end else begin
            cen_r        <= cen_s;
            dec_r        <= dec_s;
            uni_r        <= uni_s;
            ptr_r        <= ptr_s;
            car_dato_r   <= car_dato_s;
            car_valido_r <= car_valido_s;
            car_ultimo_r <= car_ultimo_s;
            fin_r        <= fin_s;
            ocupado_r    <= ocupado_s;
            desbordado_r <= desbordado_s;
        end
    end

    assign ocupado    = ocupado_r;
    assign car_dato   = car_dato_r;
    assign car_valido = car_valido_r;
    assign car_ultimo = car_ultimo_r;
    assign fin        = fin_r;
    assign desbordado = desbordado_r;

endmodule
